down_counter_timer: RTL and testbench

- Loadable, parameterised down-counter with terminal-count pulse; counts in the opposite direction to the team's 4-bit up-counter.
- Used as a programmable delay or timeout generator.
- A value is loaded and then decremented once per enabled cycle.
- Reaching zero raises a one-cycle `tc` pulse.

---
 rtl/down_counter_timer_if.sv | 36 +++
 rtl/down_counter_timer.sv | 102 ++++++++++
 tb/tb_down_counter_timer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if
//   Signal bundle for the loadable down-counter timer.
//   master modport : the block that drives the commands (clr, load, load_val,
//                    en, and auto_reload when DOWN_COUNTER_TIMER_RELOAD_EN is
//                    defined) and observes count/tc/busy.
//   slave modport  : the timer itself.
//   Handshake: there is no valid/ready pair. Every command input is a level
//   sampled on each rising clk edge. Every status output is registered and
//   changes only on that edge or on asynchronous reset.
//   Optional macro: DOWN_COUNTER_TIMER_RELOAD_EN adds the auto_reload input.
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
  logic             auto_reload;
`endif
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;

`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
  modport master (output clr, load, load_val, en, auto_reload,
                  input  count, tc, busy);
  modport slave  (input  clr, load, load_val, en, auto_reload,
                  output count, tc, busy);
`else
  modport master (output clr, load, load_val, en,
                  input  count, tc, busy);
  modport slave  (input  clr, load, load_val, en,
                  output count, tc, busy);
`endif
endinterface

// File: rtl/down_counter_timer.sv
// down_counter_timer
//   Loadable down-counter used as a programmable delay or timeout. A load
//   captures a start value. Each enabled cycle in RUN then decrements the
//   count. Reaching zero gives a one-cycle tc pulse, and the block parks in
//   DONE until the next load.
//   Ports:
//     clk       rising-edge clock
//     rst       asynchronous reset, active-low
//     bus       down_counter_timer_if.slave (clr, load, load_val, en,
//               [auto_reload], count, tc, busy)
//     state_dbg current FSM state (0 IDLE, 1 RUN, 2 DONE)
//   Optional macro: DOWN_COUNTER_TIMER_RELOAD_EN. When it is defined, a
//   terminal event with auto_reload=1 reloads the count from the last loaded
//   value and stays in RUN, so tc repeats periodically.
//   Edge priority: clr > load > decrement > hold.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  down_counter_timer_if.slave     bus,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (bus.clr) begin
      // reload_q is left untouched by clr.
      count_d = '0;
      state_d = S_IDLE;
    end else if (bus.load) begin
      // A load of zero parks in IDLE and never produces tc.
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = (bus.load_val != '0) ? S_RUN : S_IDLE;
    end else if (state_q == S_RUN && bus.en) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        tc_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
        if (bus.auto_reload) begin
          // RUN is only entered with a non-zero load, so reload_q is non-zero
          // here and the count never reloads to zero.
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = S_DONE;
        end
`else
        count_d = '0;
        state_d = S_DONE;
`endif
      end else begin
        // A zero count in RUN cannot arise from the transitions above. Park
        // the block safely instead of wrapping below zero.
        state_d = S_DONE;
      end
    end

    // busy is registered from the next state, so it falls on the tc edge.
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         auto_reload = 1'b0;
  logic [1:0]   state_dbg;

  down_counter_timer_if #(.WIDTH(W)) bus ();
  assign bus.clr      = clr;
  assign bus.load     = load;
  assign bus.load_val = load_val;
  assign bus.en       = en;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
  assign bus.auto_reload = auto_reload;
`endif

  down_counter_timer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The timer is tracked as "remaining enabled cycles" plus a running flag.
  // Each edge, the model pushes the expected {busy, tc, count} for that edge.
  int m_cnt     = 0;
  int m_rel     = 0;
  bit m_running = 0;
  bit m_tc      = 0;
  logic [W+1:0] exp_q[$];

  always @(negedge rst) begin
    m_cnt = 0; m_rel = 0; m_running = 0; m_tc = 0;
    exp_q.delete();
  end

  always @(posedge clk) begin
    if (rst) begin
      m_tc = 0;
      if (clr) begin
        m_cnt = 0; m_running = 0;
      end else if (load) begin
        m_cnt = int'(load_val); m_rel = int'(load_val);
        m_running = (load_val != 0);
      end else if (m_running && en) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_tc = 1;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
          if (auto_reload) m_cnt = m_rel;
          else m_running = 0;
`else
          m_running = 0;
`endif
        end
      end
      exp_q.push_back({m_running, m_tc, W'(m_cnt)});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (!rst) begin
      check("rst_count", int'(bus.count), 0);
      check("rst_tc",    int'(bus.tc),    0);
      check("rst_busy",  int'(bus.busy),  0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_count", int'(bus.count), int'(e[W-1:0]));
      check("sb_tc",    int'(bus.tc),    int'(e[W]));
      check("sb_busy",  int'(bus.busy),  int'(e[W+1]));
    end
  end

  // ---------------- driver tasks ----------------
  // Apply inputs just after a falling edge and return at the next falling edge.
  task automatic step(input bit c, input bit l, input int v, input bit e, input bit ar);
    clr = c; load = l; load_val = W'(v); en = e; auto_reload = ar;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int c, input int t, input int b);
    check({name, "_count"}, int'(bus.count), c);
    check({name, "_tc"},    int'(bus.tc),    t);
    check({name, "_busy"},  int'(bus.busy),  b);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq3_en [7]  = '{1, 0, 0, 1, 1, 0, 1};
    int seq3_cnt [7] = '{3, 3, 3, 2, 1, 1, 0};

    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);

    // 1: asynchronous reset while counting from 9
    step(0, 1, 9, 0, 0);
    lit("t1_load", 9, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    lit("t1_mid", 7, 0, 1);
    #2 rst = 1'b0;
    #1 lit("t1_async", 0, 0, 0);
    check("t1_state", int'(state_dbg), 0);
    #3 rst = 1'b1;
    @(negedge clk);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    lit("t1_after", 0, 0, 0);

    // 2: load 5, run continuously
    step(0, 1, 5, 0, 0);
    lit("t2_load", 5, 0, 1);
    for (int i = 4; i >= 1; i--) begin
      step(0, 0, 0, 1, 0);
      lit("t2_run", i, 0, 1);
    end
    step(0, 0, 0, 1, 0);
    lit("t2_term", 0, 1, 0);
    step(0, 0, 0, 1, 0);
    lit("t2_done", 0, 0, 0);
    check("t2_state", int'(state_dbg), 2);

    // 3: enable gaps
    step(0, 1, 4, 0, 0);
    lit("t3_load", 4, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, seq3_en[i][0], 0);
      lit("t3_step", seq3_cnt[i], (i == 6) ? 1 : 0, (i == 6) ? 0 : 1);
    end

    // 4: clr beats load, then a load of zero
    step(0, 1, 15, 0, 0);
    repeat (12) step(0, 0, 0, 1, 0);
    lit("t4_at3", 3, 0, 1);
    step(1, 1, 9, 1, 0);
    lit("t4_clr", 0, 0, 0);
    check("t4_state", int'(state_dbg), 0);
    step(0, 1, 0, 1, 0);
    lit("t4_load0", 0, 0, 0);
    step(0, 0, 0, 1, 0);
    lit("t4_hold", 0, 0, 0);

    // 5: load on the terminal edge wins
    step(0, 1, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    lit("t5_at1", 1, 0, 1);
    step(0, 1, 7, 1, 0);
    lit("t5_reload", 7, 0, 1);

`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
    // 6: periodic auto-reload, then one-shot finish
    step(0, 1, 3, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, 1);
      lit("t6_per", (i % 3 == 2) ? 3 : 2 - (i % 3), (i % 3 == 2) ? 1 : 0, 1);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    lit("t6_end", 0, 1, 0);
`endif

    // random phase: scoreboard against the model
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        #4 rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
      end
      step($urandom_range(0, 31) == 0,
           $urandom_range(0, 7) == 0,
           int'($urandom_range(0, (1 << W) - 1)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1);
    end

    step(0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
